serial_word_assembler: RTL and testbench

- Upstream stage of the combinational parity generator: turns a bit-serial frame into the 16-bit word that drives the generator's a_i.
- Frame format: WIDTH data bits, LSB first, followed by one parity bit.
- Shifts bits in, checks the received parity bit, and presents the word with an error flag over a valid/ready handshake.
- The output register double-buffers, so the next frame can be collected while the current word waits for acceptance.

---
 rtl/parity_pkg.sv | 17 +
 rtl/sat_counter.sv | 32 +++
 rtl/serial_word_assembler.sv | 149 ++++++++++++++
 tb/tb_serial_word_assembler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the serial word assembler and the parity generator it feeds.
package parity_pkg;

  // Word width shared by the assembler output and the parity generator input.
  localparam int unsigned DATA_W = 16;

  // Default parity sense: 0 = even, 1 = odd.
  localparam bit PARITY_ODD_DEF = 1'b0;

  // Assembler frame state.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StPar  = 2'd2
  } asm_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Increment unless already at the all-ones ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared synchronously.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Collects LSB-first serial frames (WIDTH data bits + parity bit) into a word,
// checks parity and presents the result over a valid/ready handshake.
module serial_word_assembler
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH      = DATA_W,
  parameter bit          PARITY_ODD = PARITY_ODD_DEF,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             parity_err_o,
  output logic             overrun_o,
  output logic             abort_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] ovr_cnt_o
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  asm_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;
  logic             abort_q, abort_d;

  logic             complete;
  logic             frame_err;
  logic             err_inc;

  // All data bits are in shreg_q by the time the parity beat arrives.
  assign frame_err = (^shreg_q) ^ bit_i ^ PARITY_ODD;

  // Frame FSM: start_i on any valid beat (re)starts a frame at bit 0.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    abort_d  = 1'b0;
    complete = 1'b0;
    if (bit_valid_i && start_i) begin
      abort_d    = (state_q != StIdle);
      shreg_d    = '0;
      shreg_d[0] = bit_i;
      cnt_d      = IdxW'(1);
      state_d    = StData;
    end else if (bit_valid_i) begin
      unique case (state_q)
        StIdle: ;
        StData: begin
          shreg_d[cnt_q] = bit_i;
          if (cnt_q == IdxW'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = StPar;
          end else begin
            cnt_d = cnt_q + IdxW'(1);
          end
        end
        StPar: begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output register: a completed frame loads only if the slot is free or drains this cycle.
  always_comb begin
    word_d  = word_q;
    perr_d  = perr_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    err_inc = 1'b0;
    if (valid_q && word_ready_i) begin
      valid_d = 1'b0;
    end
    if (complete) begin
      if (valid_q && !word_ready_i) begin
        ovr_d = 1'b1;
      end else begin
        word_d  = shreg_q;
        perr_d  = frame_err;
        valid_d = 1'b1;
        err_inc = frame_err;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
      abort_q <= abort_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk_i(clk_i),
    .clr_i(rst_i),
    .inc_i(err_inc),
    .cnt_o(err_cnt_o)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_ovr_cnt (
    .clk_i(clk_i),
    .clr_i(rst_i),
    .inc_i(ovr_d),
    .cnt_o(ovr_cnt_o)
  );

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign parity_err_o = perr_q;
  assign overrun_o    = ovr_q;
  assign abort_o      = abort_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler: scenario tasks with a queue of expected words.
module tb_serial_word_assembler;

  localparam int unsigned W     = 16;
  localparam int unsigned CW    = 8;
  localparam bit          P_ODD = 1'b0;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          bit_valid_i = 1'b0;
  logic          bit_i = 1'b0;
  logic          start_i = 1'b0;
  logic          word_ready_i = 1'b1;
  logic [W-1:0]  word_o;
  logic          word_valid_o;
  logic          parity_err_o;
  logic          overrun_o;
  logic          abort_o;
  logic          busy_o;
  logic [CW-1:0] err_cnt_o;
  logic [CW-1:0] ovr_cnt_o;

  int total = 0;
  int bad = 0;
  int exp_err = 0;
  int exp_ovr = 0;

  // {parity_err, word}
  logic [W:0] exp_q[$];

  serial_word_assembler #(
    .WIDTH(W),
    .PARITY_ODD(P_ODD),
    .CNT_W(CW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bit_valid_i(bit_valid_i),
    .bit_i(bit_i),
    .start_i(start_i),
    .word_o(word_o),
    .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i),
    .parity_err_o(parity_err_o),
    .overrun_o(overrun_o),
    .abort_o(abort_o),
    .busy_o(busy_o),
    .err_cnt_o(err_cnt_o),
    .ovr_cnt_o(ovr_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  function automatic logic exp_perr(input logic [W-1:0] d, input logic p);
    return (^d) ^ p ^ P_ODD;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic b, input logic s);
    bit_valid_i = 1'b1;
    bit_i       = b;
    start_i     = s;
    tick();
    bit_valid_i = 1'b0;
    start_i     = 1'b0;
    bit_i       = 1'b0;
  endtask

  task automatic gaps(input int unsigned gap_max);
    int unsigned n;
    n = (gap_max == 0) ? 0 : $urandom_range(0, gap_max);
    repeat (n) tick();
  endtask

  task automatic send_bits(input logic [W-1:0] d, input int from, input int unsigned gap_max);
    for (int i = from; i < W; i++) begin
      gaps(gap_max);
      drive_beat(d[i], i == 0);
    end
  endtask

  // Full frame; the expected result is queued as the parity beat goes in.
  task automatic send_frame(input logic [W-1:0] d, input logic p, input int unsigned gap_max);
    send_bits(d, 0, gap_max);
    gaps(gap_max);
    exp_q.push_back({exp_perr(d, p), d});
    drive_beat(p, 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    total++;
    if ({word_o, word_valid_o, parity_err_o, overrun_o, abort_o, busy_o, err_cnt_o, ovr_cnt_o}
        !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got word=%h v=%b pe=%b ov=%b ab=%b bz=%b ec=%0d oc=%0d want 0",
               word_o, word_valid_o, parity_err_o, overrun_o, abort_o, busy_o, err_cnt_o,
               ovr_cnt_o);
    end
  endtask

  task automatic test_clean();
    logic [W:0] e;
    word_ready_i = 1'b1;
    send_frame(16'hA5C3, 1'b0, 0);
    total++;
    if (word_valid_o !== 1'b1) begin
      bad++; $display("FAIL clean_valid: got %b want 1", word_valid_o);
    end
    e = pop_exp();
    total++;
    if ({parity_err_o, word_o} !== e) begin
      bad++; $display("FAIL clean_word: got %b/%h want %b/%h", parity_err_o, word_o, e[W], e[W-1:0]);
    end
    total++;
    if (err_cnt_o !== CW'(exp_err)) begin
      bad++; $display("FAIL clean_errcnt: got %0d want %0d", err_cnt_o, exp_err);
    end
    tick();
    total++;
    if (word_valid_o !== 1'b0) begin
      bad++; $display("FAIL clean_one_cycle: got %b want 0", word_valid_o);
    end
  endtask

  task automatic test_parity_err();
    logic [W:0] e;
    word_ready_i = 1'b1;
    send_frame(16'hA5C3, 1'b1, 0);
    exp_err++;
    e = pop_exp();
    total++;
    if ({word_valid_o, parity_err_o, word_o} !== {1'b1, e}) begin
      bad++; $display("FAIL perr_word: got v=%b pe=%b w=%h want v=1 pe=%b w=%h",
                      word_valid_o, parity_err_o, word_o, e[W], e[W-1:0]);
    end
    total++;
    if (err_cnt_o !== CW'(exp_err)) begin
      bad++; $display("FAIL perr_errcnt: got %0d want %0d", err_cnt_o, exp_err);
    end
    send_frame(16'h0001, 1'b1, 0);
    e = pop_exp();
    total++;
    if ({word_valid_o, parity_err_o, word_o} !== {1'b1, e}) begin
      bad++; $display("FAIL perr_good_word: got v=%b pe=%b w=%h want v=1 pe=%b w=%h",
                      word_valid_o, parity_err_o, word_o, e[W], e[W-1:0]);
    end
    total++;
    if (err_cnt_o !== CW'(exp_err)) begin
      bad++; $display("FAIL perr_errcnt_hold: got %0d want %0d", err_cnt_o, exp_err);
    end
    tick();
  endtask

  task automatic test_overrun();
    logic [W:0] e;
    word_ready_i = 1'b0;
    send_frame(16'h1234, ^16'h1234, 0);
    send_bits(16'hFFFF, 0, 0);
    drive_beat(^16'hFFFF, 1'b0);
    exp_ovr++;
    total++;
    if ({overrun_o, word_valid_o, word_o} !== {2'b11, 16'h1234}) begin
      bad++; $display("FAIL ovr_pulse: got ov=%b v=%b w=%h want ov=1 v=1 w=1234",
                      overrun_o, word_valid_o, word_o);
    end
    total++;
    if (ovr_cnt_o !== CW'(exp_ovr)) begin
      bad++; $display("FAIL ovr_cnt: got %0d want %0d", ovr_cnt_o, exp_ovr);
    end
    tick();
    total++;
    if (overrun_o !== 1'b0) begin
      bad++; $display("FAIL ovr_single: got %b want 0", overrun_o);
    end
    word_ready_i = 1'b1;
    e = pop_exp();
    total++;
    if ({word_valid_o, parity_err_o, word_o} !== {1'b1, e}) begin
      bad++; $display("FAIL ovr_held: got v=%b pe=%b w=%h want v=1 pe=%b w=%h",
                      word_valid_o, parity_err_o, word_o, e[W], e[W-1:0]);
    end
    tick();
    total++;
    if ({word_valid_o, word_o} !== {1'b0, 16'h1234}) begin
      bad++; $display("FAIL ovr_drain: got v=%b w=%h want v=0 w=1234", word_valid_o, word_o);
    end
  endtask

  task automatic test_same_cycle();
    logic [W:0] e;
    word_ready_i = 1'b0;
    send_frame(16'h1111, ^16'h1111, 0);
    send_bits(16'h2222, 0, 0);
    word_ready_i = 1'b1;
    e = pop_exp();
    total++;
    if ({word_valid_o, parity_err_o, word_o} !== {1'b1, e}) begin
      bad++; $display("FAIL same_held: got v=%b pe=%b w=%h want v=1 pe=%b w=%h",
                      word_valid_o, parity_err_o, word_o, e[W], e[W-1:0]);
    end
    exp_q.push_back({exp_perr(16'h2222, ^16'h2222), 16'h2222});
    drive_beat(^16'h2222, 1'b0);
    total++;
    if ({overrun_o, ovr_cnt_o} !== {1'b0, CW'(exp_ovr)}) begin
      bad++; $display("FAIL same_no_ovr: got ov=%b oc=%0d want ov=0 oc=%0d",
                      overrun_o, ovr_cnt_o, exp_ovr);
    end
    e = pop_exp();
    total++;
    if ({word_valid_o, parity_err_o, word_o} !== {1'b1, e}) begin
      bad++; $display("FAIL same_new: got v=%b pe=%b w=%h want v=1 pe=%b w=%h",
                      word_valid_o, parity_err_o, word_o, e[W], e[W-1:0]);
    end
    tick();
    total++;
    if (word_valid_o !== 1'b0) begin
      bad++; $display("FAIL same_drain: got %b want 0", word_valid_o);
    end
  endtask

  task automatic test_resync_gaps();
    logic [W:0] e;
    word_ready_i = 1'b1;
    drive_beat(1'b1, 1'b1);
    for (int i = 1; i < 7; i++) drive_beat(i[0], 1'b0);
    total++;
    if ({busy_o, abort_o} !== 2'b10) begin
      bad++; $display("FAIL resync_busy: got bz=%b ab=%b want bz=1 ab=0", busy_o, abort_o);
    end
    tick();
    drive_beat(1'b1, 1'b1);
    total++;
    if ({abort_o, word_valid_o, busy_o} !== 3'b101) begin
      bad++; $display("FAIL resync_abort: got ab=%b v=%b bz=%b want ab=1 v=0 bz=1",
                      abort_o, word_valid_o, busy_o);
    end
    send_bits(16'h00FF, 1, 3);
    total++;
    if (abort_o !== 1'b0) begin
      bad++; $display("FAIL resync_abort_single: got %b want 0", abort_o);
    end
    gaps(3);
    exp_q.push_back({exp_perr(16'h00FF, 1'b0), 16'h00FF});
    drive_beat(1'b0, 1'b0);
    e = pop_exp();
    total++;
    if ({word_valid_o, parity_err_o, word_o} !== {1'b1, e}) begin
      bad++; $display("FAIL resync_word: got v=%b pe=%b w=%h want v=1 pe=%b w=%h",
                      word_valid_o, parity_err_o, word_o, e[W], e[W-1:0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    word_ready_i = 1'b0;
    send_frame(16'h5A5A, ^16'h5A5A, 0);
    drive_beat(1'b1, 1'b1);
    for (int i = 1; i < 5; i++) drive_beat(1'b1, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    exp_err = 0;
    exp_ovr = 0;
    total++;
    if ({word_o, word_valid_o, parity_err_o, overrun_o, abort_o, busy_o, err_cnt_o, ovr_cnt_o}
        !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: got word=%h v=%b pe=%b ov=%b ab=%b bz=%b ec=%0d oc=%0d",
               word_o, word_valid_o, parity_err_o, overrun_o, abort_o, busy_o, err_cnt_o,
               ovr_cnt_o);
    end
    word_ready_i = 1'b1;
    for (int i = 5; i <= W; i++) drive_beat(1'b1, 1'b0);
    tick();
    total++;
    if ({word_valid_o, busy_o} !== 2'b00) begin
      bad++; $display("FAIL midrst_no_word: got v=%b bz=%b want 0 0", word_valid_o, busy_o);
    end
  endtask

  task automatic test_back_to_back_sat();
    logic [W:0]   e;
    logic [W-1:0] d;
    word_ready_i = 1'b1;
    for (int n = 0; n < 300; n++) begin
      d = W'($urandom);
      send_frame(d, ~(^d) ^ P_ODD, 0);
      if (exp_err < (1 << CW) - 1) exp_err++;
      e = pop_exp();
      total++;
      if ({word_valid_o, parity_err_o, word_o, err_cnt_o} !== {1'b1, e, CW'(exp_err)}) begin
        bad++; $display("FAIL sat_frame%0d: got v=%b pe=%b w=%h ec=%0d want v=1 pe=%b w=%h ec=%0d",
                        n, word_valid_o, parity_err_o, word_o, err_cnt_o, e[W], e[W-1:0],
                        exp_err);
      end
    end
    tick();
    total++;
    if ({err_cnt_o, ovr_cnt_o, word_valid_o} !== {8'd255, 8'd0, 1'b0}) begin
      bad++; $display("FAIL sat_final: got ec=%0d oc=%0d v=%b want ec=255 oc=0 v=0",
                      err_cnt_o, ovr_cnt_o, word_valid_o);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_clean();
    test_parity_err();
    test_overrun();
    test_same_cycle();
    test_resync_gaps();
    test_reset_mid_frame();
    test_back_to_back_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
